// File: rtl/hazard_if.sv
// ID-stage hazard query bus between decode (master) and the hazard scoreboard (slave).
interface hazard_if #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned LAT_W = 3
);
    localparam int unsigned AW = $clog2(NREG);

    logic             id_valid;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic             rs1_used;
    logic             rs2_used;
    logic [AW-1:0]    rd;
    logic             rd_write;
    logic [LAT_W-1:0] wb_lat;
    logic             is_ecall;
    logic             flush;
    logic             stall;
    logic [NREG-1:0]  busy_mask;

    modport master (
        output id_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_write, wb_lat, is_ecall, flush,
        input  stall, busy_mask
    );

    modport slave (
        input  id_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_write, wb_lat, is_ecall, flush,
        output stall, busy_mask
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register writeback-latency scoreboard producing the ID-stage stall (load-use, ecall gap).
// Define HAZARD_STALL_CNT_EN to add the saturating 32-bit stall_cnt output.
module hazard_scoreboard #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned LAT_W     = 3,
    parameter int unsigned ECALL_REG = 17,
    parameter int unsigned ECALL_GAP = 2
) (
    input  logic        clk,
    input  logic        reset,
    hazard_if.slave     id_if
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int unsigned AW = $clog2(NREG);

    logic [LAT_W-1:0]     cnt_q [NREG];
    logic [LAT_W-1:0]     cnt_d [NREG];
    logic [ECALL_GAP-1:0] eg_q;
    logic [ECALL_GAP-1:0] eg_d;
    logic [NREG-1:0]      busy_c;
    logic [NREG-1:0]      busy_d;
    logic [NREG-1:0]      busy_mask_q;
    logic                 src_haz_c;
    logic                 ecall_haz_c;
    logic                 stall_c;
    logic                 issue_c;
    logic                 wr_c;

    // Register 0 is hardwired, so it never reports busy.
    always_comb begin
        busy_c = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            busy_c[i] = (cnt_q[i] != '0);
        end
    end

    assign src_haz_c   = id_if.id_valid & ((id_if.rs1_used & busy_c[id_if.rs1]) |
                                           (id_if.rs2_used & busy_c[id_if.rs2]));
    assign ecall_haz_c = id_if.id_valid & id_if.is_ecall &
                         (busy_c[AW'(ECALL_REG)] | (eg_q != '0));
    assign stall_c     = (src_haz_c | ecall_haz_c) & ~id_if.flush;
    assign issue_c     = id_if.id_valid & ~stall_c & ~id_if.flush;
    assign wr_c        = issue_c & id_if.rd_write;

    // Next state: age all counters, then a fresh issue reloads its rd; flush wipes everything.
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : '0;
        end
        if (wr_c && (id_if.rd != '0)) begin
            cnt_d[id_if.rd] = id_if.wb_lat;
        end
        eg_d = (eg_q << 1) | ECALL_GAP'(wr_c && (id_if.rd == AW'(ECALL_REG)));
        if (id_if.flush) begin
            for (int i = 0; i < int'(NREG); i++) begin
                cnt_d[i] = '0;
            end
            eg_d = '0;
        end
        busy_d = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            busy_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                cnt_q[i] <= '0;
            end
            eg_q        <= '0;
            busy_mask_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            eg_q        <= eg_d;
            busy_mask_q <= busy_d;
        end
    end

    assign id_if.stall     = stall_c;
    assign id_if.busy_mask = busy_mask_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus randomized traffic
// checked against a cycle-timestamp model of register readiness.
module tb_hazard_scoreboard;
    localparam int unsigned NREG      = 32;
    localparam int unsigned LAT_W     = 3;
    localparam int unsigned ECALL_REG = 17;
    localparam int unsigned ECALL_GAP = 2;

    logic clk;
    logic reset;

    hazard_if #(.NREG(NREG), .LAT_W(LAT_W)) hif ();

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_scoreboard #(
        .NREG(NREG), .LAT_W(LAT_W), .ECALL_REG(ECALL_REG), .ECALL_GAP(ECALL_GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .id_if (hif)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned     tests;
    int unsigned     fails;
    int unsigned     t;
    int unsigned     free_at [NREG];
    int unsigned     ecall_free;
    logic [31:0]     exp_scnt;
    logic            last_stall;
    logic [NREG-1:0] last_busy;
    logic [31:0]     base_scnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // A register written at cycle s with latency L is readable from cycle s+L+1 on.
    function automatic logic model_busy(input int unsigned r);
        return (r != 0) && (t < free_at[r]);
    endfunction

    function automatic logic model_stall();
        logic h;
        h = hif.id_valid & ((hif.rs1_used & model_busy(hif.rs1)) |
                            (hif.rs2_used & model_busy(hif.rs2)));
        h = h | (hif.id_valid & hif.is_ecall & (model_busy(ECALL_REG) | (t < ecall_free)));
        return h & ~hif.flush & reset;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < int'(NREG); r++) free_at[r] = 0;
        ecall_free = 0;
    endfunction

    task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                         input logic w, input logic [2:0] lat, input logic ec, input logic fl);
        hif.id_valid = v;  hif.rs1 = r1; hif.rs1_used = u1; hif.rs2 = r2; hif.rs2_used = u2;
        hif.rd = rd; hif.rd_write = w; hif.wb_lat = lat; hif.is_ecall = ec; hif.flush = fl;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic cyc();
        logic            es;
        logic [NREG-1:0] eb;
        @(negedge clk);
        es = model_stall();
        for (int r = 0; r < int'(NREG); r++) eb[r] = model_busy(r);
        last_stall = hif.stall;
        last_busy  = hif.busy_mask;
        check("stall", 64'(hif.stall), 64'(es));
        check("busy_mask", 64'(hif.busy_mask), 64'(eb));
        @(posedge clk);
        if (reset) begin
            if (es) exp_scnt = exp_scnt + 32'd1;
            if (hif.flush) begin
                model_clear();
            end else if (hif.id_valid && !es && hif.rd_write) begin
                if (hif.rd != 0) free_at[hif.rd] = t + hif.wb_lat + 1;
                if (hif.rd == ECALL_REG && ecall_free < t + ECALL_GAP + 1)
                    ecall_free = t + ECALL_GAP + 1;
            end
        end
        t++;
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 3) == 0) ? 5'(ECALL_REG) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        tests = 0; fails = 0; t = 0; exp_scnt = '0;
        last_stall = 1'b0; last_busy = '0;
        model_clear();
        reset = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 64'(hif.stall), 64'd0);
        check("rst_busy", 64'(hif.busy_mask), 64'd0);
        reset = 1'b1;
        cyc();

        // Load-use: load r5 (lat 1), dependent add stalls exactly once.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd1, 1'b0, 1'b0); cyc();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 3'd0, 1'b0, 1'b0); cyc();
        check("ldu_stall_first", 64'(last_stall), 64'd1);
        check("ldu_busy5_set", 64'(last_busy[5]), 64'd1);
        cyc();
        check("ldu_stall_second", 64'(last_stall), 64'd0);
        check("ldu_busy5_clr", 64'(last_busy[5]), 64'd0);

        // Writes to r0 never create a hazard.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd3, 1'b0, 1'b0); cyc();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0); cyc();
        check("r0_stall", 64'(last_stall), 64'd0);
        check("r0_busy", 64'(last_busy), 64'd0);

        // Write to the ecall register blocks ecall for two cycles.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd17, 1'b1, 3'd0, 1'b0, 1'b0); cyc();
        drive(1'b1, 5'd17, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0); cyc();
        check("ecall_stall1", 64'(last_stall), 64'd1);
        cyc();
        check("ecall_stall2", 64'(last_stall), 64'd1);
        cyc();
        check("ecall_issue", 64'(last_stall), 64'd0);

        // Flush discards in-flight loads and does not load its own destination.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd3, 1'b0, 1'b0); cyc();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 3'd3, 1'b0, 1'b1); cyc();
        check("flush_no_stall", 64'(last_stall), 64'd0);
        drive(1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0); cyc();
        check("post_flush_stall", 64'(last_stall), 64'd0);
        check("post_flush_busy", 64'(last_busy), 64'd0);

        // Three load-use pairs add three stall cycles.
        base_scnt = exp_scnt;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd1, 1'b0, 1'b0); cyc();
            drive(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 3'd0, 1'b0, 1'b0); cyc();
            cyc();
        end
        check("three_pairs_model", 64'(exp_scnt - base_scnt), 64'd3);
`ifdef HAZARD_STALL_CNT_EN
        check("stall_cnt_pairs", 64'(stall_cnt), 64'(base_scnt + 32'd3));
`endif

        // Reset asserted while a consumer is stalled on r9.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd3, 1'b0, 1'b0); cyc();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0); cyc();
        check("pre_rst_stall", 64'(hif.stall), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_stall", 64'(hif.stall), 64'd0);
        check("mid_rst_busy", 64'(hif.busy_mask), 64'd0);
        model_clear();
        exp_scnt = '0;
`ifdef HAZARD_STALL_CNT_EN
        check("mid_rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk); @(posedge clk);
        t = t + 2;
        #1;
        reset = 1'b1;
        cyc();
        check("post_rst_stall", 64'(last_stall), 64'd0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 3) != 0, pick_reg(), 1'($urandom_range(0, 1)),
                  pick_reg(), 1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            cyc();
        end
        nop();
        cyc();
`ifdef HAZARD_STALL_CNT_EN
        check("stall_cnt_final", 64'(stall_cnt), 64'(exp_scnt));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers; register index width AW = clog2(NREG).
REQ-002 Parameter LAT_W, default 3, width of per-register latency counters.
REQ-003 Parameter ECALL_REG, default 17, register the ecall instruction reads.
REQ-004 Parameter ECALL_GAP, default 2, cycles a write to ECALL_REG blocks ecall after issue (1..7).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 id_valid  input  1  ID-stage instruction present.
REQ-008 rs1, rs2  input  AW each  source register indices.
REQ-009 rs1_used, rs2_used  input  1 each  source actually read.
REQ-010 rd  input  AW  destination index.
REQ-011 rd_write  input  1  instruction writes rd.
REQ-012 wb_lat  input  LAT_W  bubbles a dependent must wait (load = 1, ALU = 0).
REQ-013 is_ecall  input  1  ID instruction is ecall.
REQ-014 flush  input  1  squash all in-flight tracking (branch mispredict).
REQ-015 stall  output  1  combinational; hold PC and IF/ID, insert bubble.
REQ-016 busy_mask  output  NREG  registered; bit i = counter[i] != 0.

Function
REQ-017 Per-register counter cnt[i] (LAT_W bits) and one ECALL_GAP-bit shift register eg_sr shall be kept; cnt[0] is always 0.
REQ-018 src_haz = id_valid & ((rs1_used & cnt[rs1]!=0) | (rs2_used & cnt[rs2]!=0)); index 0 never hazards.
REQ-019 ecall_haz = id_valid & is_ecall & (cnt[ECALL_REG]!=0 | eg_sr!=0).
REQ-020 stall = (src_haz | ecall_haz) & !flush, same cycle as inputs, with no registered latency.
REQ-021 issue = id_valid & !stall & !flush.
REQ-022 Each cycle every nonzero cnt[i] shall decrement by 1 and saturate at 0.
REQ-023 On issue with rd_write and rd!=0, cnt[rd] shall load wb_lat on the next edge; load overrides decrement of the same entry.
REQ-024 eg_sr shall shift left each cycle, inserting 1 when issue & rd_write & rd==ECALL_REG, else 0; width ECALL_GAP.
REQ-025 Load-use timing: load issued at cycle N with wb_lat=1, dependent in ID at N+1 shall stall exactly one cycle and issue at N+2.
REQ-026 wb_lat=0 shall set no hazard (full forwarding).
REQ-027 flush shall clear all cnt and eg_sr on the next edge; flush with id_valid in the same cycle shall not issue or load any counter.
REQ-028 A stalled instruction shall not modify cnt or eg_sr.
REQ-029 busy_mask shall reflect cnt after the edge (one-cycle registered view).

Reset
REQ-030 While reset=0: all cnt=0, eg_sr=0, busy_mask=0, stall_cnt=0; stall evaluates to 0.
REQ-031 Reset asserted mid-stall shall clear state immediately; the first cycle after release shall see no hazards.

Configuration
REQ-032 Macro HAZARD_STALL_CNT_EN: when defined, add output stall_cnt (32 bits), incrementing by 1 each cycle stall=1, saturating at 0xFFFFFFFF, cleared only by reset.
REQ-033 Without HAZARD_STALL_CNT_EN, port stall_cnt and its counter shall not exist; all other behaviour is identical.

Verification
REQ-034 Load rd=5 wb_lat=1 at cycle 10; add rs1=5 at 11 -> stall=1 at 11, 0 at 12, issue at 12; busy_mask[5]=1 after the cycle-10 edge only.
REQ-035 Write rd=0 wb_lat=3, then consumer rs1=0 -> no stall, busy_mask=0.
REQ-036 addi rd=17 at cycle 20, ecall at 21, ECALL_GAP=2 -> stall at 21 and 22, ecall issues at 23.
REQ-037 Load rd=7 wb_lat=3, flush next cycle, consumer rs2=7 after -> no stall, busy_mask=0.
REQ-038 Consumer rs1=9 stalled by cnt[9]=2 while reset driven 0 -> stall=0, busy_mask=0 immediately; after release no stall.
REQ-039 With HAZARD_STALL_CNT_EN, three load-use pairs -> stall_cnt=3; without macro, bench compiles without the stall_cnt port.
